// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared state and op encodings for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_LSR  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    localparam int DATA_W = 16;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle between control FSM and shift sequencer
// abort is present only when SHIFT_SEQ_ABORT_EN is defined.
interface shift_sequencer_if #(parameter int AMT_W = 4);

    logic             start;
    logic [15:0]      in;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [15:0]      result;

`ifdef SHIFT_SEQ_ABORT_EN
    modport master (output start, in, op, amount, abort, input busy, done, result);
    modport slave  (input start, in, op, amount, abort, output busy, done, result);
`else
    modport master (output start, in, op, amount, input busy, done, result);
    modport slave  (input start, in, op, amount, output busy, done, result);
`endif

endinterface

// File: rtl/shift_sequencer_shifter.sv
// rtl/shift_sequencer_shifter.sv - datapath 1-bit shifter (pass/LSL/LSR/ASR)
module shifter
    import shift_seq_pkg::*;
(
    input  logic [15:0] a,
    input  logic [1:0]  shift,
    output logic [15:0] y
);

    always_comb begin
        y = a;
        case (shift)
            OP_LSL:  y = {a[14:0], 1'b0};
            OP_LSR:  y = {1'b0, a[15:1]};
            OP_ASR:  y = {a[15], a[15:1]};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift controller iterating the 1-bit shifter
// Optional abort of an in-flight shift when SHIFT_SEQ_ABORT_EN is defined.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    state_t           state;
    logic [15:0]      acc;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op_r;
    logic [15:0]      shift_y;

    shifter u_shifter (
        .a     (acc),
        .shift (op_r),
        .y     (shift_y)
    );

    // result and done are loaded on the edge that enters S_DONE, so the
    // pulse and the valid result line up in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            op_r       <= OP_PASS;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc      <= bus.in;
                        cnt      <= bus.amount;
                        op_r     <= bus.op;
                        bus.busy <= 1'b1;
                        if (bus.amount == '0 || bus.op == OP_PASS) begin
                            state      <= S_DONE;
                            bus.result <= bus.in;
                            bus.done   <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
                    if (bus.abort) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else
`endif
                    begin
                        acc <= shift_y;
                        cnt <= cnt - 1'b1;
                        if (cnt == AMT_W'(1)) begin
                            state      <= S_DONE;
                            bus.result <= shift_y;
                            bus.done   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer (abort cases under SHIFT_SEQ_ABORT_EN)
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic reset;

    shift_sequencer_if #(.AMT_W(4)) bus();

    shift_sequencer #(.AMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog expired got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] o, input int n);
        case (o)
            2'b01:   return (n >= 16) ? 16'h0000 : 16'(v << n);
            2'b10:   return (n >= 16) ? 16'h0000 : 16'(v >> n);
            2'b11:   return (n >= 16) ? {16{v[15]}} : 16'($signed(v) >>> n);
            default: return v;
        endcase
    endfunction

    // Called at a negedge; presents start for one edge and returns at cycle 1.
    task automatic issue(input logic [15:0] v, input logic [1:0] o, input logic [3:0] n,
                         input bit push, input logic [15:0] exp);
        bus.start  = 1'b1;
        bus.in     = v;
        bus.op     = o;
        bus.amount = n;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered at negedge of cycle start_cyc; returns at negedge of the cycle after done.
    task automatic wait_done(input int lat, input int start_cyc, input string name);
        int cyc;
        bit seen;
        logic [15:0] exp;
        cyc  = start_cyc;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            vectors++;
            if (bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d got %b required 1", name, cyc, bus.busy);
            end
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s done timeout got none required cycle %0d", name, lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            if (cyc != lat) begin
                miscompares++;
                $display("FAIL %s latency got %0d required %0d", name, cyc, lat);
            end
            exp = exp_q.pop_front();
            vectors++;
            if (bus.result !== exp) begin
                miscompares++;
                $display("FAIL %s result got %h required %h", name, bus.result, exp);
            end
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp) begin
                miscompares++;
                $display("FAIL %s after-done got done=%b busy=%b result=%h required 0 0 %h",
                         name, bus.done, bus.busy, bus.result, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b result=%h required 0 0 0000",
                     bus.busy, bus.done, bus.result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        issue(16'h8001, 2'b11, 4'd3, 1'b1, 16'hF000);
        wait_done(4, 1, "asr3");
        issue(16'h0001, 2'b01, 4'd15, 1'b1, 16'h8000);
        wait_done(16, 1, "lsl15");
        issue(16'h1234, 2'b01, 4'd0, 1'b1, 16'h1234);
        wait_done(1, 1, "amt0");
        issue(16'h1234, 2'b00, 4'd7, 1'b1, 16'h1234);
        wait_done(1, 1, "pass7");
    endtask

    task automatic test_back_to_back();
        issue(16'hF0F0, 2'b10, 4'd4, 1'b1, 16'h0F0F);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(5, 3, "ignored_start");
        issue(16'h00F0, 2'b01, 4'd2, 1'b1, 16'h03C0);
        wait_done(3, 1, "fresh_start");
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [1:0]  o;
        logic [3:0]  n;
        for (int i = 0; i < 10; i++) begin
            v = 16'($urandom);
            o = 2'($urandom_range(0, 3));
            n = 4'($urandom_range(0, 15));
            issue(v, o, n, 1'b1, model(v, o, int'(n)));
            wait_done((n == 4'd0 || o == 2'b00) ? 1 : int'(n) + 1, 1, "random");
        end
    endtask

    task automatic test_mid_reset();
        issue(16'h5555, 2'b01, 4'd6, 1'b1, 16'h5540);
        wait_done(7, 1, "pre_reset");
        issue(16'h00FF, 2'b01, 4'd8, 1'b0, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000) begin
            miscompares++;
            $display("FAIL mid_reset got busy=%b done=%b result=%h required 0 0 0000",
                     bus.busy, bus.done, bus.result);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_quiet got done=%b busy=%b required 0 0", bus.done, bus.busy);
            end
        end
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        issue(16'h00AA, 2'b00, 4'd0, 1'b1, 16'h00AA);
        wait_done(1, 1, "abort_prior");
        issue(16'h00FF, 2'b01, 4'd6, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h00AA) begin
            miscompares++;
            $display("FAIL abort got busy=%b done=%b result=%h required 0 0 00aa",
                     bus.busy, bus.done, bus.result);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet got done=%b required 0", bus.done);
            end
        end
        bus.abort = 1'b1;
        issue(16'h0003, 2'b01, 4'd0, 1'b1, 16'h0003);
        bus.abort = 1'b0;
        wait_done(1, 1, "abort_idle");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.in     = '0;
        bus.op     = '0;
        bus.amount = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        bus.abort  = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit datapath shifter. It accepts a shift request with a value, an operation and a shift amount. It then drives the shifter's 1-bit shift repeatedly, once per clock, until the amount is exhausted, and returns the result with a one-cycle done pulse. It sits between the control FSM and the shifter, so the datapath supports multi-bit shifts without a barrel shifter.

## Interface
- AMT_W, 4: width of the shift-amount input; amounts 0 to 2^AMT_W-1.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  input  1  request strobe; sampled only in IDLE.
- in  input  16  operand, captured when start is accepted.
- op  input  2  00 pass, 01 LSL, 10 LSR, 11 ASR (same encoding as the shifter's shift input).
- amount  input  AMT_W  number of 1-bit shifts, captured when start is accepted.
- abort  input  1  only present when SHIFT_SEQ_ABORT_EN is defined.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, result valid.
- result  output  16  registered result; holds until the next accepted start completes.

## Operation
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE with start=1: load acc<=in, cnt<=amount, op_r<=op.
  - Next state is DONE if amount==0 or op==00.
  - Otherwise next state is SHIFT.
- IDLE with start=0: remain in IDLE.
- SHIFT: shifter input is acc and its shift input is op_r. Each cycle acc<=shifter output and cnt<=cnt-1. When cnt==1, next state is DONE.
- DONE: result<=acc, done=1 for this cycle only, next state IDLE.
- start in SHIFT or DONE is ignored; no queueing, and the request is lost.
- Amount at or above 16:
  - LSL and LSR yield 16'h0000.
  - ASR yields 16{in[15]}.
  - All amounts run the full count; there is no early exit.
- Reset values: state IDLE, acc 0, cnt 0, op_r 00, result 16'h0000, done 0, busy 0.
- Reset mid-operation returns to IDLE next edge. There is no done pulse and result is cleared to 0.

## Timing
- Start accepted at edge E0.
- Amount N≥1 with op≠00: busy high cycles 1..N+1, SHIFT occupies cycles 1..N, done high in cycle N+1.
- Amount 0 or op 00: done high in cycle 1.
- Latency from start edge to done is N+1 cycles, minimum 1.
- result updates on the same edge that enters the done cycle, is valid while done=1, and is stable afterwards.
- Back-to-back operation: busy is low in the cycle after done, and start is accepted in that cycle. The sustained throughput is one request per N+2 cycles.
- done, busy and result are registered. result does not depend combinationally on in, op or amount.

## Configuration
- SHIFT_SEQ_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in SHIFT: next state IDLE, no done pulse, result keeps its previous value.
  - abort in IDLE or DONE is ignored. A simultaneous start in IDLE is accepted; DONE still pulses.
  - reset has priority over abort.
- Not defined: no abort port, and every accepted request runs to completion.

## Structure
- Package shift_seq_pkg holds:
  - state constants S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b10;
  - op constants OP_PASS, OP_LSL, OP_LSR, OP_ASR.
- Instantiate the existing shifter module once as the sole sub-module. Do not duplicate the shift logic.
- The down-counter and FSM stay in shift_sequencer.

## Test plan
- in=16'h8001, op=11, amount=3, start pulse -> done in cycle 4, result=16'hF000, busy high cycles 1-4.
- in=16'h0001, op=01, amount=15 -> done in cycle 16, result=16'h8000.
- in=16'h1234, op=01, amount=0 -> done in cycle 1, result=16'h1234. Also op=00, amount=7 -> done in cycle 1, result=16'h1234.
- in=16'hF0F0, op=10, amount=4. Second start with in=16'hFFFF in cycle 2 -> ignored, done in cycle 5, result=16'h0F0F. Fresh start in cycle 6 is accepted.
- Reset asserted in cycle 2 of an amount=8 op -> state IDLE, busy=0 and result=0 next cycle; done never pulses.
- With SHIFT_SEQ_ABORT_EN: prior result 16'h00AA, then start in=16'h00FF, op=01, amount=6, abort in cycle 3 -> no done, result stays 16'h00AA, busy=0 in cycle 4.
